// File: rtl/knapsack_search.sv
// Sequential sweep driver for the 5-item knapsack checker: walks all 32 selections
// and reports the highest-value one the combinational checker marks valid.
module knapsack_search #(
  parameter int W     = 5,
  parameter int VAL_A = 4,
  parameter int VAL_B = 2,
  parameter int VAL_C = 2,
  parameter int VAL_D = 1,
  parameter int VAL_E = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         abort,
  output logic [4:0]   sel,
  input  logic         valid_in,
  output logic         busy,
  output logic         done,
  output logic         found,
  output logic [4:0]   best_sel,
  output logic [W-1:0] best_value
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SWEEP = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]   state;
  logic [4:0]   count;
  logic         trk_found;
  logic [4:0]   trk_sel;
  logic [W-1:0] trk_value;
  logic [W-1:0] cur_value;
  logic         take;
  logic         last;

  always_comb begin
    busy = (state == SWEEP);
    done = (state == DONE);
    sel  = (state == SWEEP) ? count : 5'd0;
  end

  always_comb begin
    cur_value = (sel[0] ? W'(VAL_A) : '0)
              + (sel[1] ? W'(VAL_B) : '0)
              + (sel[2] ? W'(VAL_C) : '0)
              + (sel[3] ? W'(VAL_D) : '0)
              + (sel[4] ? W'(VAL_E) : '0);
  end

  // Strict greater-than keeps the lowest-index selection on value ties.
  always_comb begin
    take = (state == SWEEP) && !abort && valid_in &&
           (!trk_found || (cur_value > trk_value));
    last = (state == SWEEP) && !abort && (count == 5'd31);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      count      <= 5'd0;
      trk_found  <= 1'b0;
      trk_sel    <= 5'd0;
      trk_value  <= '0;
      found      <= 1'b0;
      best_sel   <= 5'd0;
      best_value <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            trk_found <= 1'b0;
            trk_sel   <= 5'd0;
            trk_value <= '0;
            count     <= 5'd0;
            state     <= SWEEP;
          end
        end
        SWEEP: begin
          if (abort) begin
            state <= IDLE;
          end else begin
            if (take) begin
              trk_found <= 1'b1;
              trk_sel   <= count;
              trk_value <= cur_value;
            end
            if (count == 5'd31) begin
              state <= DONE;
            end else begin
              count <= count + 5'd1;
            end
          end
          // Publish on the edge into DONE (folding in the final evaluation) so the
          // result is already visible in the cycle that done is high.
          if (last) begin
            found      <= take ? 1'b1      : trk_found;
            best_sel   <= take ? count     : trk_sel;
            best_value <= take ? cur_value : trk_value;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_knapsack_search.sv
// Self-checking bench for knapsack_search: a cycle-level reference model checked every
// cycle, plus directed sweeps with hand-computed literal results.
module tb_knapsack_search;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        valid_in;
  logic [4:0]  sel;
  logic        busy;
  logic        done;
  logic        found;
  logic [4:0]  best_sel;
  logic [4:0]  best_value;
  logic [31:0] mask = 32'd0;

  int  pass_cnt = 0;
  int  total_cnt = 0;
  bit  check_en = 1'b0;

  int        phase = 0;
  logic      m_found = 1'b0;
  logic [4:0] m_sel = 5'd0;
  logic [4:0] m_val = 5'd0;

  knapsack_search #(.W(5), .VAL_A(4), .VAL_B(2), .VAL_C(2), .VAL_D(1), .VAL_E(10)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .sel(sel),
    .valid_in(valid_in), .busy(busy), .done(done), .found(found),
    .best_sel(best_sel), .best_value(best_value)
  );

  always #5 clk = ~clk;

  // The checker under test is a lookup mask indexed by the presented selection.
  assign valid_in = mask[sel];

  function automatic int itemValue(input int s);
    int vals [5];
    int v;
    vals = '{4, 2, 2, 1, 10};
    v = 0;
    for (int i = 0; i < 5; i++) if (s[i]) v += vals[i];
    return v;
  endfunction

  // Classic knapsack: weights 12,2,1,1,4 with capacity 15.
  function automatic logic [31:0] realMask();
    int wts [5];
    int w;
    logic [31:0] m;
    wts = '{12, 2, 1, 1, 4};
    m = 32'd0;
    for (int s = 0; s < 32; s++) begin
      w = 0;
      for (int i = 0; i < 5; i++) if (s[i]) w += wts[i];
      m[s] = (w <= 15);
    end
    return m;
  endfunction

  // Returns {found, sel, value} for the best valid selection, lowest index on ties.
  function automatic logic [10:0] bestOf(input logic [31:0] m);
    int  bv;
    int  bs;
    logic f;
    bv = 0; bs = 0; f = 1'b0;
    for (int s = 0; s < 32; s++) begin
      if (m[s] && (!f || itemValue(s) > bv)) begin
        f = 1'b1; bv = itemValue(s); bs = s;
      end
    end
    return {f, 5'(bs), 5'(bv)};
  endfunction

  // phase 0 = idle, 1..32 = sweeping selection phase-1, 33 = done cycle.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase   <= 0;
      m_found <= 1'b0;
      m_sel   <= 5'd0;
      m_val   <= 5'd0;
    end else if (phase == 0) begin
      if (start) phase <= 1;
    end else if (phase <= 32) begin
      if (abort) begin
        phase <= 0;
      end else begin
        phase <= phase + 1;
        if (phase == 32) {m_found, m_sel, m_val} <= bestOf(mask);
      end
    end else begin
      phase <= 0;
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    total_cnt++;
    if (actual == expected) pass_cnt++;
    else $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("busy", int'(busy), (phase >= 1 && phase <= 32) ? 1 : 0);
      checkOutput("sel", int'(sel), (phase >= 1 && phase <= 32) ? phase - 1 : 0);
      checkOutput("done", int'(done), (phase == 33) ? 1 : 0);
      checkOutput("found", int'(found), int'(m_found));
      checkOutput("best_sel", int'(best_sel), int'(m_sel));
      checkOutput("best_value", int'(best_value), int'(m_val));
    end
  end

  task automatic checkResults(input string tag, input int f, input int s, input int v);
    checkOutput({tag, " found"}, int'(found), f);
    checkOutput({tag, " best_sel"}, int'(best_sel), s);
    checkOutput({tag, " best_value"}, int'(best_value), v);
  endtask

  // Pulses start with the given checker mask, then times the sweep to done.
  task automatic applyStimulus(input string tag, input logic [31:0] m,
                               input int f, input int s, input int v);
    int n;
    @(posedge clk); #2;
    mask  = m;
    start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    n = 1;
    while (!done && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput({tag, " latency"}, n, 33);
    checkResults(tag, f, s, v);
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    checkResults("reset", 0, 0, 0);
    checkOutput("reset busy", int'(busy), 0);
    #1;
    rst_n    = 1'b1;
    check_en = 1'b1;

    applyStimulus("all_zero", 32'h0000_0000, 0, 0, 0);
    applyStimulus("tie_3_5_20", (32'd1 << 3) | (32'd1 << 5) | (32'd1 << 20), 1, 20, 12);
    applyStimulus("tie_3_5", (32'd1 << 3) | (32'd1 << 5), 1, 3, 6);
    applyStimulus("all_one", 32'hFFFF_FFFF, 1, 31, 19);
    applyStimulus("real", realMask(), 1, 30, 15);

    // Abort partway through a sweep that would otherwise yield 31/19.
    @(posedge clk); #2;
    mask  = 32'hFFFF_FFFF;
    start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    checkOutput("abort sel", int'(sel), 10);
    #1;
    abort = 1'b1;
    @(posedge clk); #1;
    checkOutput("abort busy", int'(busy), 0);
    checkOutput("abort done", int'(done), 0);
    checkResults("abort", 1, 30, 15);
    #1;
    abort = 1'b0;
    applyStimulus("after_abort", 32'hFFFF_FFFF, 1, 31, 19);

    // Asynchronous reset mid-sweep clears everything at once.
    @(posedge clk); #2;
    mask  = realMask();
    start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    repeat (17) @(posedge clk);
    #1;
    checkOutput("pre_reset sel", int'(sel), 17);
    #1;
    rst_n = 1'b0;
    #1;
    checkResults("mid_reset", 0, 0, 0);
    checkOutput("mid_reset busy", int'(busy), 0);
    checkOutput("mid_reset sel", int'(sel), 0);
    @(posedge clk); #2;
    rst_n = 1'b1;

    // A start pulse during the sweep must not restart it.
    @(posedge clk); #2;
    start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    n = 1;
    repeat (4) begin
      @(posedge clk); #1;
      n++;
    end
    #1;
    start = 1'b1;
    @(posedge clk); #1;
    n++;
    #1;
    start = 1'b0;
    while (!done && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("ignored_start latency", n, 33);
    checkResults("ignored_start", 1, 30, 15);

    repeat (3) @(posedge clk);
    check_en = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog");
  end

endmodule
